// File: rtl/factor_search_engine_if.sv
// Request/result bundle for factor_search_engine: the master issues start/target,
// the slave reports busy/done and the found factor pair.
interface factor_search_engine_if #(
    parameter int AW = 5,
    parameter int BW = 3
);
    localparam int PW = AW + BW;

    logic          start;
    logic [PW-1:0] target;
    logic          busy;
    logic          done;
    logic          found;
    logic [AW-1:0] fact_a;
    logic [BW-1:0] fact_b;

    modport master (
        output start, target,
        input  busy, done, found, fact_a, fact_b
    );

    modport slave (
        input  start, target,
        output busy, done, found, fact_a, fact_b
    );
endinterface

// File: rtl/factor_search_engine.sv
// Brute-force factor search: walks (a, b) with a outer and b inner, multiplies each
// pair with a BW-cycle shift-add loop and stops at the first product equal to target.
//
// state | meaning
// IDLE  | waiting for start; results held
// MUL   | one shift-add step per cycle over the bits of b
// CMP   | compare product with target, then finish or step to next pair
// DONE  | one-cycle done pulse, then back to IDLE
module factor_search_engine #(
    parameter int AW = 5,
    parameter int BW = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    factor_search_engine_if.slave   bus
);
    localparam int PW = AW + BW;
    localparam int IW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(BW - 1);
    localparam logic [AW-1:0] A_MAX  = {AW{1'b1}};
    localparam logic [BW-1:0] B_MAX  = {BW{1'b1}};

    typedef enum logic [1:0] {IDLE, MUL, CMP, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] n_r;
    logic [PW-1:0] acc_r;
    logic [AW-1:0] a_r;
    logic [BW-1:0] b_r;
    logic [IW-1:0] i_r;
    logic          found_r;
    logic [AW-1:0] fa_r;
    logic [BW-1:0] fb_r;

    logic match;
    logic last_pair;

    assign match     = (acc_r == n_r);
    assign last_pair = (a_r == A_MAX) && (b_r == B_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = MUL;
            MUL:  if (i_r == I_LAST) state_d = CMP;
            CMP:  state_d = (match || last_pair) ? DONE : MUL;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n_r     <= '0;
            acc_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            i_r     <= '0;
            found_r <= 1'b0;
            fa_r    <= '0;
            fb_r    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        n_r     <= bus.target;
                        a_r     <= AW'(2);
                        b_r     <= BW'(2);
                        acc_r   <= '0;
                        i_r     <= '0;
                        found_r <= 1'b0;
                        fa_r    <= '0;
                        fb_r    <= '0;
                    end
                end
                MUL: begin
                    // a*b < 2^PW, so the accumulator never overflows
                    if (b_r[i_r]) acc_r <= acc_r + (PW'(a_r) << i_r);
                    i_r <= i_r + 1'b1;
                end
                CMP: begin
                    if (match) begin
                        found_r <= 1'b1;
                        fa_r    <= a_r;
                        fb_r    <= b_r;
                    end else if (!last_pair) begin
                        if (b_r == B_MAX) begin
                            b_r <= BW'(2);
                            a_r <= a_r + 1'b1;
                        end else begin
                            b_r <= b_r + 1'b1;
                        end
                        acc_r <= '0;
                        i_r   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_q == MUL) || (state_q == CMP);
    assign bus.done   = (state_q == DONE);
    assign bus.found  = found_r;
    assign bus.fact_a = fa_r;
    assign bus.fact_b = fb_r;
endmodule

// File: tb/tb_factor_search_engine.sv
// Bench for factor_search_engine: an edge-count model predicts every output each
// cycle, and directed runs pin done latency and results to hand-computed values.
module tb_factor_search_engine;
    localparam int AW = 5;
    localparam int BW = 3;
    localparam int PW = AW + BW;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    factor_search_engine_if #(.AW(AW), .BW(BW)) bus();
    factor_search_engine #(.AW(AW), .BW(BW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // first match in a-outer/b-inner order; k is the candidate index where the search ends
    function automatic void search(input int n, output bit f, output int fa,
                                   output int fb, output int k);
        int idx;
        f = 0; fa = 0; fb = 0; k = -1; idx = 0;
        for (int a = 2; a < (1 << AW); a++) begin
            for (int b = 2; b < (1 << BW); b++) begin
                if (!f && a * b == n) begin
                    f = 1; fa = a; fb = b; k = idx;
                end
                idx++;
            end
        end
        if (!f) k = idx - 1;
    endfunction

    int          edge_n = 0;
    bit          m_active = 0;
    int          m_acc_e = 0;
    int          m_done_e = 0;
    bit          r_found;
    int          r_a, r_b, r_k;
    logic        e_busy = 0, e_done = 0, e_found = 0;
    logic [AW-1:0] e_a = '0;
    logic [BW-1:0] e_b = '0;
    bit          chk_en = 0;

    always @(posedge clock) begin
        edge_n++;
        if (reset) begin
            m_active = 0;
            e_busy = 0; e_done = 0; e_found = 0; e_a = '0; e_b = '0;
        end else begin
            if (bus.start && (!m_active || edge_n >= m_done_e + 2)) begin
                search(int'(bus.target), r_found, r_a, r_b, r_k);
                m_active = 1;
                m_acc_e  = edge_n;
                m_done_e = edge_n + (BW + 1) * (r_k + 1);
                e_found = 0; e_a = '0; e_b = '0;
            end
            e_busy = m_active && edge_n >= m_acc_e && edge_n < m_done_e;
            e_done = m_active && edge_n == m_done_e;
            if (e_done) begin
                e_found = r_found;
                e_a = AW'(r_a);
                e_b = BW'(r_b);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            total++;
            if ({bus.busy, bus.done, bus.found, bus.fact_a, bus.fact_b} !==
                {e_busy, e_done, e_found, e_a, e_b}) begin
                bad++;
                $display("FAIL model edge=%0d got busy=%b done=%b found=%b a=%0d b=%0d want busy=%b done=%b found=%b a=%0d b=%0d",
                         edge_n, bus.busy, bus.done, bus.found, bus.fact_a, bus.fact_b,
                         e_busy, e_done, e_found, e_a, e_b);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge inside the DONE cycle
    task automatic run(input int t, input int xf, input int xa, input int xb,
                       input int xcyc, input int pulse_at, input string nm);
        int n;
        bit seen;
        n = 0; seen = 0;
        bus.target = PW'(t);
        bus.start  = 1'b1;
        while (!seen && n < 800) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            bus.start = 1'b0;
            if (n == pulse_at) begin
                bus.target = PW'(4);
                bus.start  = 1'b1;
            end
            if (n == 1) chk({nm, "_clr"}, int'(bus.found), 0);
            if (bus.done) seen = 1;
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_cyc"}, n, xcyc);
        chk({nm, "_found"}, int'(bus.found), xf);
        chk({nm, "_a"}, int'(bus.fact_a), xa);
        chk({nm, "_b"}, int'(bus.fact_b), xb);
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.target = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_en = 1;
        reset = 1'b0;
        chk("rst_outs", int'({bus.busy, bus.done, bus.found, bus.fact_a, bus.fact_b}), 0);

        run(4, 1, 2, 2, 5, 0, "t4");
        @(negedge clock);
        run(15, 1, 3, 5, 41, 0, "t15");
        repeat (5) @(negedge clock);
        chk("hold_found", int'(bus.found), 1);
        chk("hold_a", int'(bus.fact_a), 3);
        chk("hold_b", int'(bus.fact_b), 5);
        run(61, 0, 0, 0, 721, 0, "t61");
        @(negedge clock);
        run(217, 1, 31, 7, 721, 0, "t217");
        @(negedge clock);
        run(255, 0, 0, 0, 721, 0, "t255");
        @(negedge clock);
        run(15, 1, 3, 5, 41, 10, "ign");
        @(negedge clock);

        bus.target = PW'(15);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_outs", int'({bus.busy, bus.done, bus.found, bus.fact_a, bus.fact_b}), 0);
        dones = 0;
        repeat (60) begin
            @(negedge clock);
            if (bus.done) dones++;
        end
        chk("abort_nodone", dones, 0);
        run(6, 1, 2, 3, 9, 0, "t6");
        @(negedge clock);
        run(1, 0, 0, 0, 721, 0, "b2b");
        repeat (3) @(negedge clock);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
